// File: rtl/fsr_multi_ch_ctrl_if.sv
// Tagged sample stream from the XADC wrapper into fsr_multi_ch_ctrl.
// Master drives channel tag and sample; slave (the controller) consumes them.
interface fsr_multi_ch_ctrl_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 12
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              sample_valid;
    logic [CH_W-1:0]   sample_ch;
    logic [DATA_W-1:0] sample_data;

    modport master (output sample_valid, output sample_ch, output sample_data);
    modport slave  (input  sample_valid, input  sample_ch, input  sample_data);
endinterface

// File: rtl/fsr_multi_ch_ctrl.sv
// Multi-channel force-sensor controller: per-channel windowed averaging,
// debounced hysteresis press detection and speed quantisation, feeding the
// pong core's BTN_LR / Speed inputs.
// Optional macro FSR_DIR_INVERT_EN adds a dir_invert input that swaps BTN_LR.
module fsr_multi_ch_ctrl #(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 12,
    parameter int SPEED_W    = 4,
    parameter int AVG_LOG2   = 2,
    parameter int THRESH_ON  = 1200,
    parameter int THRESH_OFF = 900,
    parameter int DEBOUNCE   = 3
) (
    input  logic                      CLK100MHZ,
    input  logic                      RST_BTN,
`ifdef FSR_DIR_INVERT_EN
    input  logic                      dir_invert,
`endif
    fsr_multi_ch_ctrl_if.slave        smp,
    output logic [NUM_CH-1:0]         press,
    output logic [NUM_CH*SPEED_W-1:0] speed,
    output logic [1:0]                BTN_LR,
    output logic [SPEED_W-1:0]        Speed,
    output logic                      out_valid
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    typedef enum logic {ST_RELEASED, ST_PRESSED} press_state_t;

    logic [ACC_W-1:0]   acc_q   [NUM_CH];
    logic [ACC_W-1:0]   acc_d   [NUM_CH];
    logic [CNT_W-1:0]   cnt_q   [NUM_CH];
    logic [CNT_W-1:0]   cnt_d   [NUM_CH];
    press_state_t       state_q [NUM_CH];
    press_state_t       state_d [NUM_CH];
    logic [3:0]         dcnt_q  [NUM_CH];
    logic [3:0]         dcnt_d  [NUM_CH];
    logic [SPEED_W-1:0] spd_q   [NUM_CH];
    logic [SPEED_W-1:0] spd_d   [NUM_CH];

    logic               fin_vld_q, fin_vld_d;
    logic [CH_W-1:0]    fin_ch_q, fin_ch_d;
    logic [DATA_W-1:0]  avg_q, avg_d;
    logic [1:0]         btn_lr_q, btn_lr_d;
    logic [SPEED_W-1:0] game_speed_q, game_speed_d;
    logic               out_valid_q, out_valid_d;

    logic               accept;
    logic [ACC_W-1:0]   sum;
    logic [SPEED_W-1:0] spd_raw;
    logic [1:0]         btn_raw;

    // Accept only in-range channel tags; no backpressure.
    always_comb begin
        accept = smp.sample_valid && ({1'b0, smp.sample_ch} < (CH_W+1)'(NUM_CH));
    end

    // Stage 1: accumulate; on the last sample of a window emit the average.
    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        fin_vld_d = 1'b0;
        fin_ch_d  = '0;
        avg_d     = '0;
        sum       = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (accept && smp.sample_ch == CH_W'(k)) begin
                sum = acc_q[k] + ACC_W'(smp.sample_data);
                if ((AVG_LOG2 == 0) || (cnt_q[k] == '1)) begin
                    acc_d[k]  = '0;
                    cnt_d[k]  = '0;
                    fin_vld_d = 1'b1;
                    fin_ch_d  = CH_W'(k);
                    avg_d     = DATA_W'(sum >> AVG_LOG2);
                end else begin
                    acc_d[k] = sum;
                    cnt_d[k] = cnt_q[k] + 1'b1;
                end
            end
        end
    end

    // Stage 2: per-channel debounced hysteresis FSM, speed and derived outputs.
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        spd_d   = spd_q;
        spd_raw = avg_q[DATA_W-1 -: SPEED_W];
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (fin_vld_q && fin_ch_q == CH_W'(k)) begin
                dcnt_d[k] = '0;
                case (state_q[k])
                    ST_RELEASED: begin
                        if (avg_q > DATA_W'(THRESH_ON)) begin
                            if (dcnt_q[k] + 4'd1 == 4'(DEBOUNCE)) state_d[k] = ST_PRESSED;
                            else                                  dcnt_d[k]  = dcnt_q[k] + 4'd1;
                        end
                    end
                    default: begin
                        if (avg_q < DATA_W'(THRESH_OFF)) begin
                            if (dcnt_q[k] + 4'd1 == 4'(DEBOUNCE)) state_d[k] = ST_RELEASED;
                            else                                  dcnt_d[k]  = dcnt_q[k] + 4'd1;
                        end
                    end
                endcase
                if (state_d[k] == ST_PRESSED) spd_d[k] = (spd_raw == '0) ? SPEED_W'(1) : spd_raw;
                else                          spd_d[k] = '0;
            end
        end
        // Recomputed every cycle from the next-state view so an inversion
        // toggle lands on the following edge even without a window update.
        btn_raw = {(state_d[0] == ST_PRESSED) && (state_d[1] != ST_PRESSED),
                   (state_d[1] == ST_PRESSED) && (state_d[0] != ST_PRESSED)};
        btn_lr_d = btn_raw;
`ifdef FSR_DIR_INVERT_EN
        if (dir_invert) btn_lr_d = {btn_raw[0], btn_raw[1]};
`endif
        game_speed_d = (spd_d[0] > spd_d[1]) ? spd_d[0] : spd_d[1];
        out_valid_d  = fin_vld_q;
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK100MHZ) begin
        if (RST_BTN) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                acc_q[k]   <= '0;
                cnt_q[k]   <= '0;
                state_q[k] <= ST_RELEASED;
                dcnt_q[k]  <= '0;
                spd_q[k]   <= '0;
            end
            fin_vld_q    <= 1'b0;
            fin_ch_q     <= '0;
            avg_q        <= '0;
            btn_lr_q     <= '0;
            game_speed_q <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            dcnt_q       <= dcnt_d;
            spd_q        <= spd_d;
            fin_vld_q    <= fin_vld_d;
            fin_ch_q     <= fin_ch_d;
            avg_q        <= avg_d;
            btn_lr_q     <= btn_lr_d;
            game_speed_q <= game_speed_d;
            out_valid_q  <= out_valid_d;
        end
    end

    // Output mapping from registered state.
    always_comb begin
        press = '0;
        speed = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            press[k]                    = (state_q[k] == ST_PRESSED);
            speed[k*SPEED_W +: SPEED_W] = spd_q[k];
        end
        BTN_LR    = btn_lr_q;
        Speed     = game_speed_q;
        out_valid = out_valid_q;
    end
endmodule

// File: tb/tb_fsr_multi_ch_ctrl.sv
// Directed bench for fsr_multi_ch_ctrl (defaults, plus a NUM_CH=3 instance
// for tag-range checks). FSR_DIR_INVERT_EN enables the inversion scenario.
module tb_fsr_multi_ch_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
`ifdef FSR_DIR_INVERT_EN
    logic dir_invert;
`endif

    fsr_multi_ch_ctrl_if #(.NUM_CH(4), .DATA_W(12)) smp ();
    fsr_multi_ch_ctrl_if #(.NUM_CH(3), .DATA_W(12)) smp3 ();

    logic [3:0]  press;
    logic [15:0] speed;
    logic [1:0]  btn_lr;
    logic [3:0]  game_speed;
    logic        out_valid;

    logic [2:0]  press3;
    logic [11:0] speed3;
    logic [1:0]  btn_lr3;
    logic [3:0]  game_speed3;
    logic        out_valid3;

    fsr_multi_ch_ctrl #(.NUM_CH(4)) u_dut (
        .CLK100MHZ (clk),
        .RST_BTN   (rst),
`ifdef FSR_DIR_INVERT_EN
        .dir_invert(dir_invert),
`endif
        .smp       (smp),
        .press     (press),
        .speed     (speed),
        .BTN_LR    (btn_lr),
        .Speed     (game_speed),
        .out_valid (out_valid)
    );

    fsr_multi_ch_ctrl #(.NUM_CH(3)) u_dut3 (
        .CLK100MHZ (clk),
        .RST_BTN   (rst),
`ifdef FSR_DIR_INVERT_EN
        .dir_invert(1'b0),
`endif
        .smp       (smp3),
        .press     (press3),
        .speed     (speed3),
        .BTN_LR    (btn_lr3),
        .Speed     (game_speed3),
        .out_valid (out_valid3)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int ov_cnt  = 0;
    int ov3_cnt = 0;
    int ov0;

    // Count out_valid pulses shortly after each active edge.
    always @(posedge clk) begin
        #1;
        if (out_valid)  ov_cnt++;
        if (out_valid3) ov3_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic send(input int ch, input int data);
        smp.sample_valid = 1'b1;
        smp.sample_ch    = 2'(ch);
        smp.sample_data  = 12'(data);
        @(negedge clk);
        smp.sample_valid = 1'b0;
    endtask

    task automatic send3(input int ch, input int data);
        smp3.sample_valid = 1'b1;
        smp3.sample_ch    = 2'(ch);
        smp3.sample_data  = 12'(data);
        @(negedge clk);
        smp3.sample_valid = 1'b0;
    endtask

    // Four samples then the cycle where the window's outputs are visible.
    task automatic send_window(input int ch, input int d0, input int d1, input int d2, input int d3);
        send(ch, d0); send(ch, d1); send(ch, d2); send(ch, d3);
        @(negedge clk);
        check($sformatf("out_valid_ch%0d", ch), out_valid, 1);
    endtask

    task automatic windows(input int ch, input int d, input int n);
        repeat (n) send_window(ch, d, d, d, d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timed out at %0t", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
`ifdef FSR_DIR_INVERT_EN
        dir_invert = 1'b0;
`endif
        smp.sample_valid = 0;  smp.sample_ch = '0;  smp.sample_data = '0;
        smp3.sample_valid = 0; smp3.sample_ch = '0; smp3.sample_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_press", press, 0);
        check("rst_speed", speed, 0);
        check("rst_btn", btn_lr, 0);
        check("rst_Speed", game_speed, 0);
        check("rst_out_valid", out_valid, 0);

        // Scenario 1: ch0 at 2000 for 12 samples.
        ov0 = ov_cnt;
        send_window(0, 2000, 2000, 2000, 2000);
        check("s1_press_w1", press, 0);
        send_window(0, 2000, 2000, 2000, 2000);
        check("s1_press_w2", press, 0);
        send(0, 2000); send(0, 2000); send(0, 2000); send(0, 2000);
        check("s1_press_lat1", press, 0);
        check("s1_ov_lat1", out_valid, 0);
        @(negedge clk);
        check("s1_press_lat2", press, 4'b0001);
        check("s1_ov_lat2", out_valid, 1);
        check("s1_btn", btn_lr, 2'b10);
        check("s1_speed0", speed[3:0], 7);
        check("s1_Speed", game_speed, 7);
        @(negedge clk);
        check("s1_ov_pulse_end", out_valid, 0);
        check("s1_ov_count", ov_cnt - ov0, 3);

`ifdef FSR_DIR_INVERT_EN
        // Scenario 6: inversion acts on the next edge.
        dir_invert = 1'b1;
        @(negedge clk);
        check("s6_btn_inv", btn_lr, 2'b01);
        dir_invert = 1'b0;
        @(negedge clk);
        check("s6_btn_norm", btn_lr, 2'b10);
`endif

        // Scenario 2: hysteresis band holds, debounce restarts on interruption.
        windows(0, 1000, 5);
        check("s2_band_press", press[0], 1);
        check("s2_band_speed0", speed[3:0], 3);
        windows(0, 800, 2);
        send_window(0, 1000, 1000, 1000, 1000);
        windows(0, 800, 2);
        check("s2_hold_press", press[0], 1);
        check("s2_hold_speed0", speed[3:0], 3);
        send_window(0, 800, 800, 800, 800);
        check("s2_rel_press", press[0], 0);
        check("s2_rel_speed0", speed[3:0], 0);
        check("s2_rel_btn", btn_lr, 2'b00);
        check("s2_rel_Speed", game_speed, 0);

        // Scenario 3: both pressed, then release ch0.
        windows(0, 2000, 3);
        check("s3_btn_left", btn_lr, 2'b10);
        windows(1, 3000, 3);
        check("s3_press_both", press[1:0], 2'b11);
        check("s3_btn_both", btn_lr, 2'b00);
        check("s3_Speed_max", game_speed, 11);
        send_window(0, 0, 0, 0, 0);
        check("s3_forced_speed0", speed[3:0], 1);
        check("s3_still_press0", press[0], 1);
        windows(0, 0, 2);
        check("s3_rel_press0", press[0], 0);
        check("s3_rel_speed0", speed[3:0], 0);
        check("s3_btn_right", btn_lr, 2'b01);
        check("s3_Speed_ch1", game_speed, 11);

        // Scenario 4: averaging 4095,4095,0,1 -> 2047.
        repeat (3) send_window(2, 4095, 4095, 0, 1);
        check("s4_press2", press[2], 1);
        check("s4_speed2", speed[11:8], 7);
        check("s4_btn", btn_lr, 2'b01);
        check("s4_Speed", game_speed, 11);

        // Threshold is strict: 1200 never counts, 1201 does.
        windows(3, 1200, 3);
        check("thr_eq_press3", press[3], 0);
        windows(3, 1201, 3);
        check("thr_gt_press", press, 4'b1110);
        check("thr_gt_speed3", speed[15:12], 4);

        // Back-to-back completions on ch2 and ch3.
        ov0 = ov_cnt;
        repeat (4) begin
            send(2, 2047);
            send(3, 1201);
        end
        check("b2b_ov_first", out_valid, 1);
        @(negedge clk);
        check("b2b_ov_second", out_valid, 1);
        @(negedge clk);
        check("b2b_ov_count", ov_cnt - ov0, 2);
        check("b2b_press", press, 4'b1110);

        // Scenario 5: reset mid-window discards partial sums and the reset-cycle sample.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("s5_rst_press", press, 0);
        check("s5_rst_btn", btn_lr, 0);
        send(0, 4095); send(0, 4095);
        smp.sample_valid = 1'b1; smp.sample_ch = 2'd0; smp.sample_data = 12'd4095;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        smp.sample_valid = 1'b0;
        ov0 = ov_cnt;
        send_window(0, 1000, 1000, 1000, 1000);
        @(negedge clk);
        check("s5_one_window", ov_cnt - ov0, 1);
        windows(0, 2000, 2);
        check("s5_no_mixed_press", press[0], 0);
        windows(0, 2000, 1);
        check("s5_press_after3", press[0], 1);

        // Out-of-range tag on the 3-channel instance.
        ov0 = ov3_cnt;
        repeat (4) send3(3, 4000);
        repeat (2) @(negedge clk);
        check("tag_oor_ov", ov3_cnt - ov0, 0);
        check("tag_oor_press", press3, 0);
        repeat (3) begin
            send3(2, 2000); send3(2, 2000); send3(2, 2000); send3(2, 2000);
            @(negedge clk);
            check("tag_ch2_ov", out_valid3, 1);
        end
        check("tag_ch2_press", press3, 3'b100);
        check("tag_ch2_speed", speed3[11:8], 7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
